// File: rtl/csr_exc_if.sv
`default_nettype none
// ============================================================================
//  Module   : csr_exc_if
//  Purpose  : WB-to-CSR commit bus. It carries CSR read/write, exception and
//             ertn commits, and interrupt lines. It returns read data,
//             interrupt pending, flush and redirect.
//  Revision : 1.0  initial release
// ============================================================================
interface csr_exc_if;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic        flush;
  logic [31:0] redirect_pc;

  // Pipeline (write-back) side
  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush,
           hw_int_in, ipi_int_in,
    input  csr_rvalue, has_int, flush, redirect_pc
  );

  // CSR file / exception sequencer side
  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush,
           hw_int_in, ipi_int_in,
    output csr_rvalue, has_int, flush, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/csr_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : csr_exc_ctrl
//  Purpose  : Architectural CSR file, exception entry / ertn sequencer,
//             stable timer and interrupt-pending logic beside the WB stage.
//  Revision : 1.0  initial release
// ============================================================================
module csr_exc_ctrl #(
  parameter logic [31:0] TID_INIT = 32'h0,
  parameter int          TIMER_W  = 32
) (
  input logic      clk,
  input logic      reset,
  csr_exc_if.slave bus
);

  localparam logic [13:0] c_CSR_CRMD   = 14'h000;
  localparam logic [13:0] c_CSR_PRMD   = 14'h001;
  localparam logic [13:0] c_CSR_ECFG   = 14'h004;
  localparam logic [13:0] c_CSR_ESTAT  = 14'h005;
  localparam logic [13:0] c_CSR_ERA    = 14'h006;
  localparam logic [13:0] c_CSR_EENTRY = 14'h00C;
  localparam logic [13:0] c_CSR_SAVE0  = 14'h030;
  localparam logic [13:0] c_CSR_SAVE1  = 14'h031;
  localparam logic [13:0] c_CSR_SAVE2  = 14'h032;
  localparam logic [13:0] c_CSR_SAVE3  = 14'h033;
  localparam logic [13:0] c_CSR_TID    = 14'h040;
  localparam logic [13:0] c_CSR_TCFG   = 14'h041;
  localparam logic [13:0] c_CSR_TVAL   = 14'h042;
  localparam logic [13:0] c_CSR_TICLR  = 14'h044;

  // LIE bit 10 has no interrupt source behind it, so it is never stored.
  localparam logic [12:0]        c_LIE_MASK = 13'h1BFF;
  localparam logic [TIMER_W-1:0] c_TVAL_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

  logic [1:0]         r_crmd_plv;
  logic               r_crmd_ie;
  logic [1:0]         r_prmd_pplv;
  logic               r_prmd_pie;
  logic [12:0]        r_ecfg_lie;
  logic [1:0]         r_is_sw;
  logic [7:0]         r_is_hw;
  logic               r_is_ti;
  logic               r_is_ipi;
  logic [5:0]         r_estat_ecode;
  logic [8:0]         r_estat_esub;
  logic [31:0]        r_era;
  logic [25:0]        r_eentry;
  logic [31:0]        r_save [4];
  logic [31:0]        r_tid;
  logic [31:0]        r_tcfg;
  logic [TIMER_W-1:0] r_tval;

  logic [12:0]        w_is;
  logic [31:0]        w_tval_ext;
  logic [31:0]        w_rdata;
  logic [31:0]        w_new;
  logic               w_wr;
  logic               w_tcfg_wr;
  logic               w_ticlr;
  logic               w_fire;
  logic [31:0]        w_load_full;
  logic [31:0]        w_reload_full;

  assign w_is = {r_is_ipi, r_is_ti, 1'b0, r_is_hw, r_is_sw};

  // Zero-extend the timer counter to the 32-bit CSR view
  always_comb begin
    w_tval_ext = '0;
    w_tval_ext[TIMER_W-1:0] = r_tval;
  end

  // Combinational read mux from current state (no write forwarding)
  always_comb begin
    w_rdata = '0;
    case (bus.csr_num)
      c_CSR_CRMD:   w_rdata = {28'b0, 1'b1, r_crmd_ie, r_crmd_plv};
      c_CSR_PRMD:   w_rdata = {29'b0, r_prmd_pie, r_prmd_pplv};
      c_CSR_ECFG:   w_rdata = {19'b0, r_ecfg_lie};
      c_CSR_ESTAT:  w_rdata = {1'b0, r_estat_esub, r_estat_ecode, 3'b0, w_is};
      c_CSR_ERA:    w_rdata = r_era;
      c_CSR_EENTRY: w_rdata = {r_eentry, 6'b0};
      c_CSR_SAVE0:  w_rdata = r_save[0];
      c_CSR_SAVE1:  w_rdata = r_save[1];
      c_CSR_SAVE2:  w_rdata = r_save[2];
      c_CSR_SAVE3:  w_rdata = r_save[3];
      c_CSR_TID:    w_rdata = r_tid;
      c_CSR_TCFG:   w_rdata = r_tcfg;
      c_CSR_TVAL:   w_rdata = w_tval_ext;
      default:      w_rdata = '0;
    endcase
  end

  // Masked merge against the old value; each register keeps only its
  // writable fields. TICLR reads 0, so its merge is just the written bits.
  assign w_new     = (w_rdata & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);
  assign w_wr      = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;
  assign w_tcfg_wr = w_wr && (bus.csr_num == c_CSR_TCFG);
  assign w_ticlr   = w_wr && (bus.csr_num == c_CSR_TICLR) && w_new[0];
  assign w_fire    = r_tcfg[0] && (r_tval == c_TVAL_ONE);

  assign w_load_full   = {w_new[31:2], 2'b00};
  assign w_reload_full = {r_tcfg[31:2], 2'b00};

  // Privilege state, exception context and software-interrupt bits
  always_ff @(posedge clk) begin
    if (reset) begin
      r_crmd_plv    <= '0;
      r_crmd_ie     <= 1'b0;
      r_prmd_pplv   <= '0;
      r_prmd_pie    <= 1'b0;
      r_era         <= '0;
      r_estat_ecode <= '0;
      r_estat_esub  <= '0;
      r_is_sw       <= '0;
    end else if (bus.wb_ex) begin
      r_prmd_pplv   <= r_crmd_plv;
      r_prmd_pie    <= r_crmd_ie;
      r_crmd_plv    <= '0;
      r_crmd_ie     <= 1'b0;
      r_era         <= bus.wb_pc;
      r_estat_ecode <= bus.wb_ecode;
      r_estat_esub  <= bus.wb_esubcode;
    end else if (bus.ertn_flush) begin
      r_crmd_plv <= r_prmd_pplv;
      r_crmd_ie  <= r_prmd_pie;
    end else if (w_wr) begin
      case (bus.csr_num)
        c_CSR_CRMD: begin
          r_crmd_plv <= w_new[1:0];
          r_crmd_ie  <= w_new[2];
        end
        c_CSR_PRMD: begin
          r_prmd_pplv <= w_new[1:0];
          r_prmd_pie  <= w_new[2];
        end
        c_CSR_ESTAT: r_is_sw <= w_new[1:0];
        c_CSR_ERA:   r_era   <= w_new;
        default: ;
      endcase
    end
  end

  // Configuration and scratch registers, written only by committed CSR writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ecfg_lie <= '0;
      r_eentry   <= '0;
      for (int i = 0; i < 4; i++) r_save[i] <= '0;
      r_tid      <= TID_INIT;
      r_tcfg     <= '0;
    end else if (w_wr) begin
      case (bus.csr_num)
        c_CSR_ECFG:   r_ecfg_lie <= w_new[12:0] & c_LIE_MASK;
        c_CSR_EENTRY: r_eentry   <= w_new[31:6];
        c_CSR_SAVE0, c_CSR_SAVE1, c_CSR_SAVE2, c_CSR_SAVE3:
                      r_save[bus.csr_num[1:0]] <= w_new;
        c_CSR_TID:    r_tid      <= w_new;
        c_CSR_TCFG:   r_tcfg     <= w_new;
        default: ;
      endcase
    end
  end

  // Timer countdown, interrupt line sampling and sticky timer interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tval   <= '0;
      r_is_ti  <= 1'b0;
      r_is_hw  <= '0;
      r_is_ipi <= 1'b0;
    end else begin
      r_is_hw  <= bus.hw_int_in;
      r_is_ipi <= bus.ipi_int_in;
      if (w_tcfg_wr)
        r_tval <= w_load_full[TIMER_W-1:0];
      else if (w_fire)
        r_tval <= r_tcfg[1] ? w_reload_full[TIMER_W-1:0] : '0;
      else if (r_tcfg[0] && (r_tval != '0))
        r_tval <= r_tval - c_TVAL_ONE;
      // A fire in the same cycle as a TICLR write keeps the interrupt set
      if (w_fire)
        r_is_ti <= 1'b1;
      else if (w_ticlr)
        r_is_ti <= 1'b0;
    end
  end

  assign bus.csr_rvalue  = w_rdata;
  assign bus.flush       = bus.wb_ex | bus.ertn_flush;
  assign bus.redirect_pc = bus.wb_ex ? {r_eentry, 6'b0} : r_era;
  assign bus.has_int     = r_crmd_ie & (|(w_is & r_ecfg_lie));

endmodule
`default_nettype wire

// File: tb/tb_csr_exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_exc_ctrl
//  Purpose  : Self-checking bench for csr_exc_ctrl: directed scenarios with
//             literal expectations, then randomized commits against a
//             register-image reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_csr_exc_ctrl;

  localparam logic [31:0] c_TID_INIT = 32'h1234_5678;
  localparam int c_TCFG = 'h41;
  localparam int c_TVAL = 'h42;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmp_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] m_reg [128];

  csr_exc_if bus ();

  csr_exc_ctrl #(.TID_INIT(c_TID_INIT), .TIMER_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: plain register images ----------------
  function automatic logic known(input logic [13:0] n);
    case (n)
      14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h0C,
      14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42: known = 1'b1;
      default: known = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] writable(input logic [13:0] n);
    case (n)
      14'h00, 14'h01: writable = 32'h7;
      14'h04:         writable = 32'h1BFF;
      14'h05:         writable = 32'h3;
      14'h0C:         writable = 32'hFFFF_FFC0;
      14'h06, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41: writable = 32'hFFFF_FFFF;
      default:        writable = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] n);
    m_read = known(n) ? m_reg[n[6:0]] : 32'h0;
  endfunction

  function automatic logic m_has_int();
    logic [31:0] is_lie;
    is_lie = m_reg[5] & m_reg[4] & 32'h1FFF;
    m_has_int = m_reg[0][2] && (is_lie != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_reg[i] = 32'h0;
    m_reg[0]    = 32'h8;
    m_reg['h40] = c_TID_INIT;
  endtask

  task automatic model_step();
    logic [31:0] old_tcfg, old_tval, wm, est;
    logic fire, tcfg_wr, ticlr;
    old_tcfg = m_reg[c_TCFG];
    old_tval = m_reg[c_TVAL];
    fire     = old_tcfg[0] && old_tval == 1;
    tcfg_wr  = 1'b0;
    ticlr    = 1'b0;
    if (bus.wb_ex) begin
      m_reg[1] = m_reg[0] & 32'h7;
      m_reg[0] = 32'h8;
      m_reg[6] = bus.wb_pc;
      m_reg[5] = (m_reg[5] & 32'h0000_FFFF) | ({23'b0, bus.wb_esubcode} << 22)
                 | ({26'b0, bus.wb_ecode} << 16);
    end else if (bus.ertn_flush) begin
      m_reg[0] = 32'h8 | (m_reg[1] & 32'h7);
    end else if (bus.csr_we) begin
      wm = writable(bus.csr_num) & bus.csr_wmask;
      if (known(bus.csr_num))
        m_reg[bus.csr_num[6:0]] = (m_reg[bus.csr_num[6:0]] & ~wm) | (bus.csr_wvalue & wm);
      tcfg_wr = (bus.csr_num == 14'h41);
      ticlr   = (bus.csr_num == 14'h44) && bus.csr_wvalue[0] && bus.csr_wmask[0];
    end
    if (tcfg_wr)
      m_reg[c_TVAL] = m_reg[c_TCFG] & ~32'h3;
    else if (old_tcfg[0] && old_tval != 0) begin
      m_reg[c_TVAL] = old_tval - 1;
      if (m_reg[c_TVAL] == 0 && old_tcfg[1]) m_reg[c_TVAL] = old_tcfg & ~32'h3;
    end
    est = m_reg[5];
    est[9:2] = bus.hw_int_in;
    est[12]  = bus.ipi_int_in;
    if (fire) est[11] = 1'b1;
    else if (ticlr) est[11] = 1'b0;
    m_reg[5] = est;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("rvalue", bus.csr_rvalue, m_read(bus.csr_num));
        check("flush", {31'b0, bus.flush}, {31'b0, bus.wb_ex | bus.ertn_flush});
        if (bus.wb_ex | bus.ertn_flush)
          check("redirect_pc", bus.redirect_pc, bus.wb_ex ? m_reg['h0C] : m_reg[6]);
        check("has_int", {31'b0, bus.has_int}, {31'b0, m_has_int()});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.csr_re = 1'b0;      bus.csr_num = '0;     bus.csr_we = 1'b0;
    bus.csr_wmask = '0;     bus.csr_wvalue = '0;  bus.wb_ex = 1'b0;
    bus.wb_ecode = '0;      bus.wb_esubcode = '0; bus.wb_pc = '0;
    bus.ertn_flush = 1'b0;  bus.hw_int_in = '0;   bus.ipi_int_in = 1'b0;
  endtask

  task automatic wr(input logic [13:0] n, input logic [31:0] v, input logic [31:0] m);
    idle();
    bus.csr_we = 1'b1; bus.csr_num = n; bus.csr_wvalue = v; bus.csr_wmask = m;
    step();
    idle();
  endtask

  task automatic chk_rd(input logic [13:0] n, input logic [31:0] exp, input string name);
    idle();
    bus.csr_re = 1'b1; bus.csr_num = n;
    #1;
    check(name, bus.csr_rvalue, exp);
    step();
  endtask

  logic [13:0] nums [17] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h0C,
                             14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41,
                             14'h42, 14'h44, 14'h44, 14'h7F, 14'h2000};

  initial begin
    idle();
    repeat (3) step();
    reset = 1'b0;
    cmp_en = 1'b1;

    // Reset values
    chk_rd(14'h00, 32'h8, "rst_crmd");
    chk_rd(14'h01, 32'h0, "rst_prmd");
    chk_rd(14'h04, 32'h0, "rst_ecfg");
    chk_rd(14'h05, 32'h0, "rst_estat");
    chk_rd(14'h06, 32'h0, "rst_era");
    chk_rd(14'h0C, 32'h0, "rst_eentry");
    for (int i = 0; i < 4; i++) chk_rd(14'h30 + 14'(i), 32'h0, "rst_save");
    chk_rd(14'h40, c_TID_INIT, "rst_tid");
    chk_rd(14'h41, 32'h0, "rst_tcfg");
    chk_rd(14'h42, 32'h0, "rst_tval");
    chk_rd(14'h7F, 32'h0, "rst_unknown");
    check("rst_has_int", {31'b0, bus.has_int}, 32'h0);

    // Exception entry
    wr(14'h00, 32'h7, 32'hFFFF_FFFF);
    wr(14'h0C, 32'h1C00_0100, 32'hFFFF_FFFF);
    idle();
    bus.wb_ex = 1'b1; bus.wb_ecode = 6'hB; bus.wb_pc = 32'h1C00_0040;
    #1;
    check("ex_flush", {31'b0, bus.flush}, 32'h1);
    check("ex_redirect", bus.redirect_pc, 32'h1C00_0100);
    step();
    chk_rd(14'h00, 32'h8, "ex_crmd");
    chk_rd(14'h01, 32'h7, "ex_prmd");
    chk_rd(14'h06, 32'h1C00_0040, "ex_era");
    chk_rd(14'h05, 32'h000B_0000, "ex_estat");

    // ertn return
    idle();
    bus.ertn_flush = 1'b1;
    #1;
    check("ertn_flush", {31'b0, bus.flush}, 32'h1);
    check("ertn_redirect", bus.redirect_pc, 32'h1C00_0040);
    step();
    chk_rd(14'h00, 32'hF, "ertn_crmd");
    chk_rd(14'h01, 32'h7, "ertn_prmd");

    // Field masking
    wr(14'h04, 32'h0000_FFFF, 32'h0000_00FF);
    chk_rd(14'h04, 32'h0000_00FF, "ecfg_mask");
    wr(14'h05, 32'h3, 32'hFFFF_FFFF);
    chk_rd(14'h05, 32'h000B_0003, "estat_is_sw");
    check("swint_has_int", {31'b0, bus.has_int}, 32'h1);
    wr(14'h0C, 32'h1C00_017F, 32'hFFFF_FFFF);
    chk_rd(14'h0C, 32'h1C00_0140, "eentry_align");
    wr(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk_rd(14'h04, 32'h0000_1BFF, "ecfg_bit10");

    // One-shot timer
    wr(14'h05, 32'h0, 32'hFFFF_FFFF);
    wr(14'h04, 32'h800, 32'hFFFF_FFFF);
    wr(14'h41, 32'h11, 32'hFFFF_FFFF);
    for (int k = 16; k >= 1; k--) begin
      idle(); bus.csr_num = 14'h42; #1;
      check("tval_oneshot", bus.csr_rvalue, 32'(k));
      check("oneshot_no_int", {31'b0, bus.has_int}, 32'h0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      idle(); bus.csr_num = 14'h42; #1;
      check("tval_halt", bus.csr_rvalue, 32'h0);
      check("oneshot_int", {31'b0, bus.has_int}, 32'h1);
      step();
    end
    wr(14'h44, 32'h1, 32'h1);
    #1;
    check("ticlr_clear", {31'b0, bus.has_int}, 32'h0);

    // Periodic timer, TICLR racing a fire
    wr(14'h41, 32'h0B, 32'hFFFF_FFFF);
    for (int k = 0; k < 12; k++) begin
      idle(); bus.csr_num = 14'h42; #1;
      check("tval_periodic", bus.csr_rvalue, 32'(8 - (k % 8)));
      step();
    end
    wr(14'h44, 32'h1, 32'h1);
    idle(); bus.csr_num = 14'h42; #1;
    check("tval_3", bus.csr_rvalue, 32'h3);
    check("periodic_cleared", {31'b0, bus.has_int}, 32'h0);
    step();
    idle(); bus.csr_num = 14'h42; #1;
    check("tval_2", bus.csr_rvalue, 32'h2);
    step();
    idle(); bus.csr_we = 1'b1; bus.csr_num = 14'h44; bus.csr_wmask = 32'h1; bus.csr_wvalue = 32'h1;
    step();
    idle(); bus.csr_num = 14'h42; #1;
    check("tval_reload", bus.csr_rvalue, 32'h8);
    check("fire_beats_ticlr", {31'b0, bus.has_int}, 32'h1);
    step();

    // Exception drops a same-cycle CSR write
    idle();
    bus.csr_we = 1'b1; bus.csr_num = 14'h30; bus.csr_wmask = 32'hFFFF_FFFF;
    bus.csr_wvalue = 32'hDEAD_BEEF; bus.wb_ex = 1'b1; bus.wb_ecode = 6'h3;
    bus.wb_pc = 32'h1C00_0200;
    step();
    chk_rd(14'h30, 32'h0, "ex_drops_write");
    chk_rd(14'h00, 32'h8, "ex2_crmd");

    // Randomized commits against the model
    idle();
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      bus.wb_ex       = (r < 4);
      bus.ertn_flush  = (r >= 2 && r < 7);
      bus.wb_ecode    = 6'($urandom);
      bus.wb_esubcode = 9'($urandom);
      bus.wb_pc       = $urandom;
      bus.csr_re      = 1'b1;
      bus.csr_we      = ($urandom_range(0, 2) == 0);
      bus.csr_num     = nums[$urandom_range(0, 16)];
      bus.csr_wmask   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.csr_wvalue  = $urandom;
      if (bus.csr_num == 14'h41) begin
        bus.csr_wvalue = 32'($urandom_range(0, 63));
        bus.csr_wmask  = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 9) == 0) bus.hw_int_in  = 8'($urandom);
      if ($urandom_range(0, 9) == 0) bus.ipi_int_in = 1'($urandom);
      step();
    end

    idle();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
